selector_tiempo: RTL and testbench
==================================

Name: selector_tiempo

Overview:
- Operator-side front end for the heating countdown block.
- Turns the up/down/clear/start panel buttons into the 5-bit `numero` setpoint and a stretched `inicio` start level.
- The heating block samples `inicio` only once every 250000 clocks, so a one-cycle pulse would be missed; this block holds it long enough to be seen.
- Editing is locked while heating runs and unlocks on the heater's `finish` strobe.

Parameters:
- DEBOUNCE_TICKS, 250000: clocks between button samples (2.5 ms at 100 MHz).
- MAX_VAL, 31: upper saturation limit of `numero`; must be ≤31.
- START_HOLD, 1000000: clocks `inicio` stays high; must be ≥4*DEBOUNCE_TICKS.
- HOLD_TICKS, 50000000: press duration before auto-repeat starts (optional feature only).
- REPEAT_TICKS, 20000000: auto-repeat step period (optional feature only).

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: asynchronous, active-high reset.
- btn_up, input, 1: raw increment button, active high.
- btn_down, input, 1: raw decrement button, active high.
- btn_clear, input, 1: raw clear button, active high.
- btn_start, input, 1: raw start button, active high.
- finish, input, 1: end-of-cycle strobe from the heating block.
- numero, output, 5: current setpoint, driven to the heating block.
- inicio, output, 1: start level to the heating block.
- busy, output, 1: high in START and RUN states.

Behaviour:
- Reset (async): numero=0, inicio=0, busy=0, state=IDLE. All counters and debounce registers are cleared.
- Sample enable:
  - Free-running counter 0..DEBOUNCE_TICKS-1.
  - `en` is high for one clk when the counter equals DEBOUNCE_TICKS-1.
- Debounce, per button:
  - 3-stage shift register q0,q1,q2, clocked only on `en`.
  - Edge pulse = q1 & ~q2 & en, exactly one clk wide.
  - The first edge pulse occurs 2 sample periods after a stable press.
- FSM states: IDLE, START, RUN.
- IDLE:
  - up edge: numero+1, saturating at MAX_VAL.
  - down edge: numero-1, saturating at 0.
  - up and down edge in the same clk: no change.
  - clear edge: numero=0. Clear has priority over up/down in the same clk.
  - start edge with numero≠0: go to START and load the hold counter. Up/down/clear edges in that same clk are ignored.
  - start edge with numero=0: ignored, stay in IDLE.
- START:
  - inicio=1 for exactly START_HOLD clks, then inicio=0 and go to RUN.
  - All button edges ignored; numero frozen.
- RUN:
  - numero frozen; all button edges ignored, including start.
  - finish=1 goes to IDLE on the next clk.
  - numero keeps its last setpoint, so the heater's standby display shows it.
- finish handling:
  - finish=1 during START: ignored; START always completes.
  - finish in IDLE: no effect.
- busy = (state≠IDLE), registered in the same clk as the state transition.
- Outputs are registered: numero changes 1 clk after the edge pulse; inicio rises 1 clk after the start edge.
- rst mid-START: inicio drops immediately (asynchronous).
- Arithmetic: 5-bit unsigned; no wrap-around in either direction.

Optional Feature:
- Macro: SELECTOR_AUTO_REPEAT_EN.
- Defined:
  - In IDLE, if exactly one of up/down stays debounced-high (q1) for HOLD_TICKS clks after its edge, an extra step is issued.
  - Further steps follow every REPEAT_TICKS while held.
  - Steps saturate as above; release resets the hold counter.
  - Both buttons held: no repeat.
- Undefined: one step per press only; the HOLD_TICKS and REPEAT_TICKS logic is absent.

Test Plan:
(Bench uses DEBOUNCE_TICKS=4, START_HOLD=16, HOLD_TICKS=40, REPEAT_TICKS=10.)
- Reset, then 3 clean up presses (each ≥12 clk high, ≥12 clk low) -> numero=3; then 2 down presses -> numero=1.
- Button high for 2 clk only (shorter than one sample period) -> numero unchanged. Bouncy press with 6 toggles within 3 clk, then stable -> exactly one increment.
- From numero=30, 3 up presses -> 31, 31, 31. From 1, 3 down presses -> 0, 0, 0. Up and down pressed together from 5 -> stays 5.
- numero=0, start press -> inicio stays 0, busy stays 0. numero=7, start press -> inicio high exactly 16 clk, busy=1. Up/clear pressed during RUN -> numero stays 7. finish pulse -> busy=0 next clk, numero still 7, up now works.
- Assert rst while in START (inicio=1) -> inicio, busy, numero all 0 asynchronously, before the next clk edge; state=IDLE after release.
- With SELECTOR_AUTO_REPEAT_EN defined: hold up from 0 for 40+3*10 clk after the first edge -> numero=5 (1 press step + 4 repeats). Without the macro, same stimulus -> numero=1.

Source files
------------

// File: rtl/selector_tiempo.sv
// Operator panel front end: debounces four buttons, edits the 5-bit setpoint and stretches the start request.
// Optional auto-repeat of up/down while held is enabled by defining SELECTOR_AUTO_REPEAT_EN.
module selector_tiempo #(
  parameter int DEBOUNCE_TICKS = 250000,
  parameter int MAX_VAL        = 31,
  parameter int START_HOLD     = 1000000,
  parameter int HOLD_TICKS     = 50000000,
  parameter int REPEAT_TICKS   = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_clear,
  input  logic       btn_start,
  input  logic       finish,
  output logic [4:0] numero,
  output logic       inicio,
  output logic       busy
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int SW = $clog2(START_HOLD + 1);
  localparam logic [4:0] MAXV = 5'(MAX_VAL);
  localparam int UP = 0;
  localparam int DN = 1;
  localparam int CL = 2;
  localparam int ST = 3;

  // An illegal parameter set shows up as this named scope in the elaborated hierarchy.
  if (MAX_VAL < 0 || MAX_VAL > 31 || START_HOLD < 4 * DEBOUNCE_TICKS ||
      HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
  end

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          en;
  logic [3:0]    btn;
  logic [3:0]    q0, q1, q2;
  logic [3:0]    pulse;
  logic [SW-1:0] hold_cnt;
  logic          rep_step;
  logic          rep_up;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= MAXV) ? MAXV : v + 5'd1;
  endfunction

  function automatic logic [4:0] sat_dec(input logic [4:0] v);
    return (v == 5'd0) ? 5'd0 : v - 5'd1;
  endfunction

  assign btn   = {btn_start, btn_clear, btn_down, btn_up};
  assign en    = (div_cnt == DW'(DEBOUNCE_TICKS - 1));
  assign pulse = q1 & ~q2 & {4{en}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     div_cnt <= '0;
    else if (en) div_cnt <= '0;
    else         div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (en) begin
      q0 <= btn;
      q1 <= q0;
      q2 <= q1;
    end
  end

`ifdef SELECTOR_AUTO_REPEAT_EN
  localparam int RW = $clog2(((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS) + 1);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_lim;
  logic          rep_first;
  logic          held_one;

  // The first step waits HOLD_TICKS after the press edge, later ones REPEAT_TICKS apart.
  assign held_one = q1[UP] ^ q1[DN];
  assign rep_lim  = rep_first ? RW'(HOLD_TICKS - 1) : RW'(REPEAT_TICKS - 1);
  assign rep_up   = q1[UP];
  assign rep_step = (state == IDLE) && held_one && (pulse == 4'b0000) && (rep_cnt == rep_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (state != IDLE || !held_one || pulse[UP] || pulse[DN]) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_cnt == rep_lim) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end
`else
  assign rep_step = 1'b0;
  assign rep_up   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      numero   <= 5'd0;
      inicio   <= 1'b0;
      busy     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pulse[ST] && numero != 5'd0) begin
            state    <= START;
            inicio   <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= SW'(START_HOLD - 1);
          end else if (pulse[CL]) begin
            numero <= 5'd0;
          end else if (pulse[UP] && !pulse[DN]) begin
            numero <= sat_inc(numero);
          end else if (pulse[DN] && !pulse[UP]) begin
            numero <= sat_dec(numero);
          end else if (rep_step) begin
            numero <= rep_up ? sat_inc(numero) : sat_dec(numero);
          end
        end
        START: begin
          // finish is deliberately ignored here so the heater always sees the full start level.
          if (hold_cnt == '0) begin
            inicio <= 1'b0;
            state  <= RUN;
          end else begin
            hold_cnt <= hold_cnt - SW'(1);
          end
        end
        RUN: begin
          if (finish) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          inicio <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_selector_tiempo.sv
// Self-checking bench for selector_tiempo: behavioural model compared every cycle, plus directed literal checks.
module tb_selector_tiempo;

  localparam int D  = 4;
  localparam int SH = 16;
  localparam int HT = 40;
  localparam int RT = 10;
  localparam int MV = 31;
`ifdef SELECTOR_AUTO_REPEAT_EN
  localparam int AR_EXP = 5;
`else
  localparam int AR_EXP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_clear = 1'b0, btn_start = 1'b0;
  logic       finish = 1'b0;
  logic [4:0] numero;
  logic       inicio, busy;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  selector_tiempo #(
    .DEBOUNCE_TICKS(D), .MAX_VAL(MV), .START_HOLD(SH),
    .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .btn_clear(btn_clear), .btn_start(btn_start), .finish(finish),
    .numero(numero), .inicio(inicio), .busy(busy)
  );

  // Model: buttons are sampled every D clocks; a press registers when the sample taken two
  // periods ago was high and the one before it was low. mode 0=idle, 1=start, 2=run.
  typedef struct packed {
    int         ph;
    logic [3:0] newest;
    logic [3:0] prev;
    logic [3:0] older;
    int         mode;
    int         left;
    int         num;
    logic       ini;
    logic       bsy;
    int         held_clk;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t c, input logic [3:0] b, input logic fin);
    mdl_t n;
    logic [3:0] e;
    bit tick, step_ok, held;
    n = c;
    tick = (c.ph == D - 1);
    e = tick ? (c.prev & ~c.older) : 4'b0000;
    n.ph = (c.ph + 1) % D;
    if (tick) begin
      n.newest = b;
      n.prev   = c.newest;
      n.older  = c.prev;
    end
    step_ok = 1'b0;
    held = c.prev[0] ^ c.prev[1];
    n.held_clk = 0;
    if (c.mode == 0) begin
`ifdef SELECTOR_AUTO_REPEAT_EN
      if (held && !e[0] && !e[1]) n.held_clk = c.held_clk + 1;
      step_ok = held && (e == 4'b0000) && n.held_clk >= HT && ((n.held_clk - HT) % RT == 0);
`endif
      if (e[3] && c.num != 0) begin
        n.mode = 1; n.ini = 1'b1; n.bsy = 1'b1; n.left = SH;
      end else if (e[2]) n.num = 0;
      else if (e[0] && !e[1]) n.num = (c.num + 1 > MV) ? MV : c.num + 1;
      else if (e[1] && !e[0]) n.num = (c.num == 0) ? 0 : c.num - 1;
      else if (step_ok) begin
        if (c.prev[0]) n.num = (c.num + 1 > MV) ? MV : c.num + 1;
        else           n.num = (c.num == 0) ? 0 : c.num - 1;
      end
    end else if (c.mode == 1) begin
      n.left = c.left - 1;
      if (n.left == 0) begin n.ini = 1'b0; n.mode = 2; end
    end else if (fin) begin
      n.mode = 0; n.bsy = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= mdl_reset();
    else     m <= mdl_step(m, {btn_start, btn_clear, btn_down, btn_up}, finish);
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      check("model_numero", numero, m.num);
      check("model_inicio", inicio, m.ini);
      check("model_busy", busy, m.bsy);
    end
  end

  task automatic set_btns(input logic [3:0] v);
    {btn_start, btn_clear, btn_down, btn_up} = v;
  endtask

  task automatic press(input logic [3:0] v, input int hi, input int lo);
    set_btns(v);
    repeat (hi) @(negedge clk);
    set_btns(4'b0000);
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish, required end before 60000 cycles");
    $fatal(1);
  end

  initial begin
    int ini_cnt;
    bit busy_seen, ini_seen;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_numero", numero, 0);
    check("reset_inicio", inicio, 0);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    cmp_on = 1'b1;

    repeat (3) press(4'b0001, 12, 12);
    check("three_up", numero, 3);
    check("model_pin_three_up", m.num, 3);
    repeat (2) press(4'b0010, 12, 12);
    check("two_down", numero, 1);

    // Short pulse placed between two sample instants.
    for (int i = 0; i < 8 && m.ph != 0; i++) @(negedge clk);
    press(4'b0001, 2, 16);
    check("short_pulse", numero, 1);

    #1 btn_up = 1'b1; #1 btn_up = 1'b0; #1 btn_up = 1'b1;
    #4 btn_up = 1'b0; #1 btn_up = 1'b1; #1 btn_up = 1'b0;
    #3 btn_up = 1'b1;
    repeat (14) @(negedge clk);
    btn_up = 1'b0;
    repeat (14) @(negedge clk);
    check("bouncy_one_step", numero, 2);
    check("model_pin_bouncy", m.num, 2);

    press(4'b0100, 12, 12);
    check("clear", numero, 0);
    repeat (30) press(4'b0001, 12, 12);
    check("up_to_30", numero, 30);
    for (int i = 0; i < 3; i++) begin
      press(4'b0001, 12, 12);
      check("sat_high", numero, 31);
    end
    press(4'b0100, 12, 12);
    press(4'b0001, 12, 12);
    for (int i = 0; i < 3; i++) begin
      press(4'b0010, 12, 12);
      check("sat_low", numero, 0);
    end
    repeat (5) press(4'b0001, 12, 12);
    press(4'b0011, 12, 12);
    check("up_down_together", numero, 5);

    press(4'b0100, 12, 12);
    set_btns(4'b1000);
    ini_seen = 0; busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ini_seen |= inicio;
      busy_seen |= busy;
      if (i == 11) set_btns(4'b0000);
    end
    check("start_at_zero_inicio", ini_seen, 0);
    check("start_at_zero_busy", busy_seen, 0);

    repeat (7) press(4'b0001, 12, 12);
    set_btns(4'b1000);
    ini_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inicio) ini_cnt++;
      finish = (inicio && ini_cnt == 3);
      if (i == 11) set_btns(4'b0000);
    end
    finish = 1'b0;
    check("inicio_width", ini_cnt, SH);
    check("busy_in_run", busy, 1);
    press(4'b0001, 12, 12);
    press(4'b0100, 12, 12);
    press(4'b1000, 12, 12);
    check("run_frozen", numero, 7);
    check("run_still_busy", busy, 1);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("finish_busy", busy, 0);
    check("finish_keeps_numero", numero, 7);
    press(4'b0001, 12, 12);
    check("up_after_finish", numero, 8);

    set_btns(4'b1000);
    for (int i = 0; i < 40 && !inicio; i++) @(negedge clk);
    set_btns(4'b0000);
    check("inicio_before_rst", inicio, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_inicio", inicio, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_numero", numero, 0);
    @(negedge clk);
    rst = 1'b0;
    press(4'b0001, 12, 12);
    check("idle_after_rst", numero, 1);
    check("idle_after_rst_busy", busy, 0);

    press(4'b0100, 12, 12);
    press(4'b0001, 78, 20);
    check("auto_repeat", numero, AR_EXP);
    check("model_pin_auto_repeat", m.num, AR_EXP);

    for (int k = 0; k < 60; k++) begin
      int r, hi, lo;
      r  = $urandom_range(0, 9);
      hi = $urandom_range(1, 24);
      lo = $urandom_range(1, 16);
      case (r)
        0, 1, 2, 3: press(4'b0001, hi, lo);
        4, 5:       press(4'b0010, hi, lo);
        6:          press(4'b0100, hi, lo);
        7:          press(4'b0011, hi, lo);
        8:          press(4'b1000, hi, lo);
        default: begin
          finish = 1'b1;
          @(negedge clk);
          finish = 1'b0;
          repeat (lo) @(negedge clk);
        end
      endcase
    end
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
